multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter: CNT_W, default 32, width of the retired-instruction counter.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 inst  input  32  current instruction word from instruction memory; sampled only in FETCH.
REQ-005 zero  input  1  ALU zero flag.
REQ-006 mem_ready  input  1  data-memory completion strobe for the current access.
REQ-007 PCen, PCSrc, RegDst, RegWrite, ALUSrc, MemRead, MemWrite, MemToReg, IRWrite  output  1 each  datapath controls.
REQ-008 ALUOp  output  4  ALU operation code.
REQ-009 retire  output  1  one-cycle pulse when an instruction completes.
REQ-010 trap  output  1  sticky illegal-instruction flag.
REQ-011 instr_count  output  CNT_W  retired-instruction count.

Function
REQ-012 FSM states SHALL be FETCH, DECODE, EXEC, MEM, WB and TRAP.
REQ-013 FETCH: IRWrite=1 and inst latched into the internal IR; next state DECODE.
REQ-014 DECODE: illegal opcode goes to TRAP; otherwise next state EXEC.
REQ-015 Legal opcodes: R-type 000000, DADDI 011000, LD 110111, SD 111111, BEQ 000100.
REQ-016 Legal R-type functs: DADD 101100, DSUB 101110, AND 100100, OR 100101, SLT 101010; any other funct is illegal.
REQ-017 ALUOp encoding: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111.
REQ-018 EXEC, R-type: ALUSrc=0, ALUOp from funct; next state WB.
REQ-019 EXEC, DADDI/LD/SD: ALUSrc=1, ALUOp=ADD; DADDI goes to WB, LD/SD go to MEM.
REQ-020 EXEC, BEQ: ALUSrc=0, ALUOp=SUB, PCSrc=zero, PCen=1, retire=1; next state FETCH.
REQ-021 MEM: MemRead (LD) or MemWrite (SD) held while mem_ready=0; state holds.
REQ-022 MEM with mem_ready=1: LD goes to WB; SD asserts PCen=1, retire=1 and goes to FETCH.
REQ-023 WB: RegWrite=1, PCen=1, retire=1; next state FETCH.
REQ-024 WB, R-type: RegDst=1, MemToReg=0.
REQ-025 WB, DADDI: RegDst=0, MemToReg=0.
REQ-026 WB, LD: RegDst=0, MemToReg=1; ALUOp/ALUSrc keep their EXEC values through MEM and WB.
REQ-027 Outputs not listed for a state SHALL be 0; outputs are combinational from state and IR (Moore, no inst passthrough).
REQ-028 Latency SHALL be BEQ 3 cycles; R-type, DADDI and SD 4 cycles; LD 5 cycles; each additional mem_ready=0 cycle adds 1.
REQ-029 PCen and retire SHALL each assert exactly once per legal instruction.
REQ-030 instr_count SHALL increment on each retire and wrap from all-ones to 0.
REQ-031 TRAP: trap=1 and all controls 0; state held until reset.
REQ-032 mem_ready outside MEM SHALL be ignored.

Reset
REQ-033 rst_n=0 at a clock edge SHALL force state FETCH, IR=0, instr_count=0 and trap=0.
REQ-034 While rst_n=0 all outputs SHALL be 0, including mid-MEM stalls, where MemRead/MemWrite drop in the reset cycle.
REQ-035 The first FETCH SHALL occur in the first cycle with rst_n=1.

Structure
REQ-036 Package mips64_ctrl_pkg SHALL hold the state enum, opcode and funct constants, and ALUOp codes.
REQ-037 Sub-module alu_decode (combinational: opcode and funct to ALUOp and a legal flag) SHALL be instantiated once.

Verification
REQ-038 Reset, then DADD (funct 101100): IRWrite in cycle 0; ALUOp=0010, ALUSrc=0 in cycle 2; RegWrite=RegDst=PCen=retire=1 in cycle 3; instr_count=1.
REQ-039 LD with mem_ready low for 2 cycles: MemRead high 3 cycles; then WB with MemToReg=1; retire at cycle 6.
REQ-040 BEQ with zero=1, then zero=0: PCSrc=1 then 0 in the EXEC cycle; 3 cycles each; no RegWrite.
REQ-041 Opcode 111000: trap=1 from cycle 2 and all controls 0 for 10 cycles; rst_n low clears trap; FETCH follows.
REQ-042 rst_n asserted during an SD MEM stall: MemWrite=0 in the reset cycle; no retire; instr_count=0.
REQ-043 Preload instr_count to all-ones via CNT_W=4 with 16 DADDIs: count wraps to 0 on the 16th retire.

Source files
------------

// File: rtl/mips64_ctrl_pkg.sv
// mips64_ctrl_pkg: states, opcode/funct constants, ALUOp codes and control bundle for the multicycle controller
package mips64_ctrl_pkg;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_DADDI = 6'b011000;
    localparam logic [5:0] OP_LD    = 6'b110111;
    localparam logic [5:0] OP_SD    = 6'b111111;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [5:0] FN_DADD = 6'b101100;
    localparam logic [5:0] FN_DSUB = 6'b101110;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    typedef struct packed {
        logic       pc_en;
        logic       pc_src;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic [3:0] alu_op;
        logic       retire;
        logic       trap;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: instruction/memory inputs and datapath control outputs of the controller
interface multicycle_control_if #(parameter int CNT_W = 32);
    logic [31:0]      inst;
    logic             zero;
    logic             mem_ready;
    logic             PCen, PCSrc, RegDst, RegWrite, ALUSrc;
    logic             MemRead, MemWrite, MemToReg, IRWrite;
    logic [3:0]       ALUOp;
    logic             retire;
    logic             trap;
    logic [CNT_W-1:0] instr_count;

    modport slave (
        input  inst, zero, mem_ready,
        output PCen, PCSrc, RegDst, RegWrite, ALUSrc, MemRead, MemWrite, MemToReg, IRWrite,
        output ALUOp, retire, trap, instr_count
    );

    modport master (
        output inst, zero, mem_ready,
        input  PCen, PCSrc, RegDst, RegWrite, ALUSrc, MemRead, MemWrite, MemToReg, IRWrite,
        input  ALUOp, retire, trap, instr_count
    );
endinterface

// File: rtl/alu_decode.sv
// alu_decode: maps opcode/funct to an ALUOp and flags encodings the controller does not support
module alu_decode
    import mips64_ctrl_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output logic [3:0] alu_op_o,
    output logic       legal_o
);

    // R-type selects by funct; immediate and memory forms add; BEQ compares by subtraction
    always_comb begin
        alu_op_o = ALU_ADD;
        legal_o  = 1'b1;
        case (opcode_i)
            OP_RTYPE: begin
                case (funct_i)
                    FN_DADD: alu_op_o = ALU_ADD;
                    FN_DSUB: alu_op_o = ALU_SUB;
                    FN_AND:  alu_op_o = ALU_AND;
                    FN_OR:   alu_op_o = ALU_OR;
                    FN_SLT:  alu_op_o = ALU_SLT;
                    default: legal_o  = 1'b0;
                endcase
            end
            OP_DADDI, OP_LD, OP_SD: alu_op_o = ALU_ADD;
            OP_BEQ:  alu_op_o = ALU_SUB;
            default: legal_o  = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: Moore FSM sequencing a MIPS64-subset multicycle datapath with retire count and illegal-op trap
module multicycle_control
    import mips64_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input logic                  clk,
    input logic                  rst_n,
    multicycle_control_if.slave  bus
);

    state_e           state_q, state_d;
    logic [31:0]      ir_q;
    logic [CNT_W-1:0] count_q;
    logic [3:0]       alu_op;
    logic             legal;
    ctrl_t            ctrl_d, ctrl;
    logic             unused_ir;

    wire [5:0] opcode = ir_q[31:26];
    wire [5:0] funct  = ir_q[5:0];
    wire       is_r   = opcode == OP_RTYPE;
    wire       is_ld  = opcode == OP_LD;
    wire       is_sd  = opcode == OP_SD;
    wire       is_beq = opcode == OP_BEQ;

    assign unused_ir = ^ir_q[25:6];

    alu_decode u_alu_decode (
        .opcode_i (opcode),
        .funct_i  (funct),
        .alu_op_o (alu_op),
        .legal_o  (legal)
    );

    // State, instruction register and retire counter; IR only captures in FETCH
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FETCH;
            ir_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == FETCH) ir_q <= bus.inst;
            if (ctrl_d.retire) count_q <= count_q + CNT_W'(1);
        end
    end

    // Next state and Moore controls; LD keeps its address-phase ALU settings through MEM and WB
    always_comb begin
        state_d = state_q;
        ctrl_d  = '0;
        case (state_q)
            FETCH: begin
                ctrl_d.ir_write = 1'b1;
                state_d         = DECODE;
            end
            DECODE: state_d = legal ? EXEC : TRAP;
            EXEC: begin
                ctrl_d.alu_op  = alu_op;
                ctrl_d.alu_src = !is_r && !is_beq;
                if (is_beq) begin
                    ctrl_d.pc_src = bus.zero;
                    ctrl_d.pc_en  = 1'b1;
                    ctrl_d.retire = 1'b1;
                    state_d       = FETCH;
                end else begin
                    state_d = (is_ld || is_sd) ? MEM : WB;
                end
            end
            MEM: begin
                ctrl_d.alu_src   = is_ld;
                ctrl_d.alu_op    = is_ld ? alu_op : ALU_AND;
                ctrl_d.mem_read  = is_ld;
                ctrl_d.mem_write = is_sd;
                if (bus.mem_ready) begin
                    ctrl_d.pc_en  = is_sd;
                    ctrl_d.retire = is_sd;
                    state_d       = is_sd ? FETCH : WB;
                end
            end
            WB: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.pc_en      = 1'b1;
                ctrl_d.retire     = 1'b1;
                ctrl_d.reg_dst    = is_r;
                ctrl_d.mem_to_reg = is_ld;
                ctrl_d.alu_src    = is_ld;
                ctrl_d.alu_op     = is_ld ? alu_op : ALU_AND;
                state_d           = FETCH;
            end
            TRAP: ctrl_d.trap = 1'b1;
            default: state_d = FETCH;
        endcase
    end

    assign ctrl            = rst_n ? ctrl_d : '0;
    assign bus.PCen        = ctrl.pc_en;
    assign bus.PCSrc       = ctrl.pc_src;
    assign bus.RegDst      = ctrl.reg_dst;
    assign bus.RegWrite    = ctrl.reg_write;
    assign bus.ALUSrc      = ctrl.alu_src;
    assign bus.MemRead     = ctrl.mem_read;
    assign bus.MemWrite    = ctrl.mem_write;
    assign bus.MemToReg    = ctrl.mem_to_reg;
    assign bus.IRWrite     = ctrl.ir_write;
    assign bus.ALUOp       = ctrl.alu_op;
    assign bus.retire      = ctrl.retire;
    assign bus.trap        = ctrl.trap;
    assign bus.instr_count = rst_n ? count_q : '0;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed instruction sequences with a per-cycle expected-control scoreboard
module tb_multicycle_control;

    localparam int CW = 4;

    localparam logic [14:0] PCEN  = 15'h4000;
    localparam logic [14:0] PCSRC = 15'h2000;
    localparam logic [14:0] RDST  = 15'h1000;
    localparam logic [14:0] RWR   = 15'h0800;
    localparam logic [14:0] ASRC  = 15'h0400;
    localparam logic [14:0] MRD   = 15'h0200;
    localparam logic [14:0] MWR   = 15'h0100;
    localparam logic [14:0] M2R   = 15'h0080;
    localparam logic [14:0] IRW   = 15'h0040;
    localparam logic [14:0] RET   = 15'h0002;
    localparam logic [14:0] TRP   = 15'h0001;
    localparam logic [14:0] NONE  = 15'h0000;

    localparam logic [5:0] OPR = 6'b000000, OPI = 6'b011000, OPL = 6'b110111, OPS = 6'b111111, OPB = 6'b000100;
    localparam logic [3:0] A_ADD = 4'b0010, A_SUB = 4'b0110;
    localparam logic [31:0] JUNK = 32'hE3A5_5A3C;

    typedef struct {
        string       name;
        logic [14:0] vec;
        logic [3:0]  cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    exp_t q[$];
    int errors = 0;
    int checks = 0;
    logic [3:0] exp_cnt = 4'd0;
    logic [14:0] got;

    always #5 clk = ~clk;

    multicycle_control_if #(.CNT_W(CW)) bus ();

    multicycle_control #(.CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign got = {bus.PCen, bus.PCSrc, bus.RegDst, bus.RegWrite, bus.ALUSrc, bus.MemRead,
                  bus.MemWrite, bus.MemToReg, bus.IRWrite, bus.ALUOp, bus.retire, bus.trap};

    function automatic logic [14:0] alu(input logic [3:0] op);
        return {9'b0, op, 2'b0};
    endfunction

    function automatic logic [31:0] enc(input logic [5:0] op, input logic [5:0] fn);
        return {op, 20'h5A3C1, fn};
    endfunction

    task automatic cyc(input string n, input logic r, input logic [31:0] i, input logic z,
                       input logic mr, input logic [14:0] v);
        @(posedge clk);
        #1;
        rst_n         = r;
        bus.inst      = i;
        bus.zero      = z;
        bus.mem_ready = mr;
        q.push_back('{n, v, r ? exp_cnt : 4'd0});
        exp_cnt = r ? exp_cnt + 4'(v[1]) : 4'd0;
    endtask

    task automatic r_type(input string n, input logic [5:0] fn, input logic [3:0] op);
        cyc({n, " F"}, 1, enc(OPR, fn), 0, 1, IRW);
        cyc({n, " D"}, 1, JUNK, 1, 1, NONE);
        cyc({n, " E"}, 1, JUNK, 1, 1, alu(op));
        cyc({n, " W"}, 1, JUNK, 1, 1, PCEN | RWR | RDST | RET);
    endtask

    task automatic daddi(input string n);
        cyc({n, " F"}, 1, enc(OPI, 6'h15), 0, 1, IRW);
        cyc({n, " D"}, 1, JUNK, 0, 1, NONE);
        cyc({n, " E"}, 1, JUNK, 0, 1, ASRC | alu(A_ADD));
        cyc({n, " W"}, 1, JUNK, 0, 1, PCEN | RWR | RET);
    endtask

    task automatic ld(input string n, input int stall);
        cyc({n, " F"}, 1, enc(OPL, 6'h08), 0, 0, IRW);
        cyc({n, " D"}, 1, JUNK, 0, 1, NONE);
        cyc({n, " E"}, 1, JUNK, 0, 1, ASRC | alu(A_ADD));
        for (int k = 0; k < stall; k++) cyc({n, " Mwait"}, 1, JUNK, 0, 0, ASRC | alu(A_ADD) | MRD);
        cyc({n, " M"}, 1, JUNK, 0, 1, ASRC | alu(A_ADD) | MRD);
        cyc({n, " W"}, 1, JUNK, 0, 1, PCEN | RWR | M2R | RET | ASRC | alu(A_ADD));
    endtask

    task automatic sd(input string n, input int stall);
        cyc({n, " F"}, 1, enc(OPS, 6'h10), 0, 1, IRW);
        cyc({n, " D"}, 1, JUNK, 0, 1, NONE);
        cyc({n, " E"}, 1, JUNK, 0, 1, ASRC | alu(A_ADD));
        for (int k = 0; k < stall; k++) cyc({n, " Mwait"}, 1, JUNK, 0, 0, MWR);
        cyc({n, " M"}, 1, JUNK, 0, 1, MWR | PCEN | RET);
    endtask

    task automatic beq(input string n, input logic z);
        cyc({n, " F"}, 1, enc(OPB, 6'h3F), !z, 1, IRW);
        cyc({n, " D"}, 1, JUNK, !z, 1, NONE);
        cyc({n, " E"}, 1, JUNK, z, 1, alu(A_SUB) | PCEN | RET | (z ? PCSRC : NONE));
    endtask

    task automatic illegal(input string n, input logic [31:0] i, input int hold);
        cyc({n, " F"}, 1, i, 0, 1, IRW);
        cyc({n, " D"}, 1, JUNK, 1, 1, NONE);
        for (int k = 0; k < hold; k++) cyc({n, " T"}, 1, enc(OPI, 6'h0), 1, 1, TRP);
        cyc({n, " rst"}, 0, JUNK, 1, 1, NONE);
    endtask

    // Scoreboard monitor: one queued expectation per clock, compared mid-cycle
    always @(negedge clk) begin
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            checks++;
            if (got !== e.vec || bus.instr_count !== e.cnt) begin
                errors++;
                $display("FAIL %s: got ctrl=%b cnt=%0d, expected ctrl=%b cnt=%0d",
                         e.name, got, bus.instr_count, e.vec, e.cnt);
            end
        end
    end

    initial begin
        rst_n         = 1'b0;
        bus.inst      = '0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;
        cyc("reset0", 0, JUNK, 1, 1, NONE);
        cyc("reset1", 0, JUNK, 1, 1, NONE);
        r_type("DADD", 6'b101100, 4'b0010);
        r_type("DSUB", 6'b101110, 4'b0110);
        r_type("AND", 6'b100100, 4'b0000);
        r_type("OR", 6'b100101, 4'b0001);
        r_type("SLT", 6'b101010, 4'b0111);
        daddi("DADDI");
        ld("LD2", 2);
        ld("LD0", 0);
        sd("SD0", 0);
        sd("SD1", 1);
        beq("BEQz1", 1'b1);
        beq("BEQz0", 1'b0);
        cyc("SDR F", 1, enc(OPS, 6'h01), 0, 1, IRW);
        cyc("SDR D", 1, JUNK, 0, 1, NONE);
        cyc("SDR E", 1, JUNK, 0, 1, ASRC | alu(A_ADD));
        cyc("SDR Mwait", 1, JUNK, 0, 0, MWR);
        cyc("SDR rst", 0, JUNK, 0, 0, NONE);
        illegal("ILLOP", enc(6'b111000, 6'b101100), 10);
        illegal("ILLFN", enc(OPR, 6'b100000), 3);
        for (int k = 0; k < 16; k++) daddi($sformatf("WRAP%0d", k));
        cyc("after wrap", 1, enc(OPI, 6'h0), 0, 1, IRW);
        for (int k = 0; k < 10 && q.size() != 0; k++) @(posedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
